// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with majority-vote sampling and valid/ready byte output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int MID   = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             samp_a;
  logic             samp_b;
  logic             vote;
  logic             at_vote;
  logic             at_end;
  logic             deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The third vote sample is the live rx_s, so the decision is available at MID+1.
  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign at_vote = (cnt == CNT_MID_P1);
  assign at_end  = (cnt == CNT_LAST);
  assign deliver = (state == S_STOP) && at_vote && vote;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else begin
      if (cnt == CNT_MID_M1) samp_a <= rx_s;
      if (cnt == CNT_MID)    samp_b <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= 3'd0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (at_vote && vote) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (at_end) begin
            state <= S_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (at_vote) shift <= {vote, shift[7:1]};
          if (at_end) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          // Leave at the stop-bit vote rather than the bit end to resync early.
          if (at_vote) begin
            cnt <= '0;
            if (vote) begin
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frames for uart_rx against a frame-level reference model.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;
  // sync (2) + idle->start (1) + 9 bit periods + stop vote at MID+1 + output register (1)
  localparam int LAT = 2 + 1 + 9 * CPB + (CPB / 2 + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int unsigned rise_q[$];
  int unsigned fe_q[$];
  int unsigned ov_q[$];
  logic [7:0]  hs_q[$];
  logic        prev_valid = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) rise_q.push_back(cyc);
    if (frame_err) fe_q.push_back(cyc);
    if (overrun) ov_q.push_back(cyc);
    if (rx_valid && rx_ready) hs_q.push_back(rx_data);
    prev_valid <= rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int n_cycles,
                            input int pulse_at, output int unsigned start);
    logic [9:0] line;
    line  = {stop, b, 1'b0};
    start = cyc;
    for (int n = 0; n < n_cycles; n++) begin
      rx = line[n / CPB];
      if (n == pulse_at) rx_ready = 1'b1;
      else if (pulse_at >= 0 && n == pulse_at + 1) rx_ready = 1'b0;
      tick(1);
    end
  endtask

  // Reference: what a correct receiver makes of one serial frame (start, 8 data LSB first, stop).
  function automatic logic [8:0] decode(input logic [9:0] line);
    logic [7:0] byte_v;
    for (int i = 0; i < 8; i++) byte_v[i] = line[i + 1];
    return {(line[0] == 1'b0) && (line[9] == 1'b1), byte_v};
  endfunction

  task automatic chk_rise(input string tag, input int unsigned start);
    chk({tag, "_rise_n"}, rise_q.size(), 1);
    if (rise_q.size() > 0) chk({tag, "_lat"}, rise_q.pop_front() - start, LAT);
  endtask

  task automatic chk_hs(input string tag, input logic [7:0] exp);
    chk({tag, "_hs_n"}, hs_q.size(), 1);
    if (hs_q.size() > 0) chk({tag, "_hs_data"}, hs_q.pop_front(), exp);
  endtask

  initial begin
    int unsigned s1;
    int unsigned s2;
    logic [7:0]  rb;
    logic        rs;
    logic [8:0]  m;

    // Reset state
    tick(4);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    idle(20);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, FRAME, -1, s1);
    chk_rise("a5", s1);
    chk_hs("a5", 8'hA5);
    chk("a5_ferr_n", fe_q.size(), 0);
    chk("a5_ovr_n", ov_q.size(), 0);
    chk("a5_valid_after", rx_valid, 0);
    idle(10);

    // Short low glitch is rejected, next frame still lands on time
    rx = 1'b0;
    tick(4);
    idle(30);
    chk("glitch_rise_n", rise_q.size(), 0);
    chk("glitch_ferr_n", fe_q.size(), 0);
    send_frame(8'h3C, 1'b1, FRAME, -1, s1);
    chk_rise("3c", s1);
    chk_hs("3c", 8'h3C);
    idle(10);

    // Bad stop bit with line held low (break)
    send_frame(8'h81, 1'b0, FRAME, -1, s1);
    rx = 1'b0;
    tick(40 - CPB);
    idle(20);
    chk("brk_ferr_n", fe_q.size(), 1);
    if (fe_q.size() > 0) chk("brk_ferr_lat", fe_q.pop_front() - s1, LAT);
    chk("brk_rise_n", rise_q.size(), 0);
    chk("brk_hs_n", hs_q.size(), 0);
    send_frame(8'h55, 1'b1, FRAME, -1, s1);
    chk_rise("55", s1);
    chk_hs("55", 8'h55);
    idle(10);

    // Overrun: two bytes without ready
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, FRAME, -1, s1);
    send_frame(8'h22, 1'b1, FRAME, -1, s2);
    chk_rise("ovr_11", s1);
    chk("ovr_rise_n2", rise_q.size(), 0);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_n", ov_q.size(), 1);
    if (ov_q.size() > 0) chk("ovr_lat", ov_q.pop_front() - s2, LAT);
    chk("ovr_hs_none", hs_q.size(), 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("ovr_valid_drop", rx_valid, 0);
    chk_hs("ovr_acc", 8'h11);
    idle(10);

    // Handshake coincides with second delivery
    send_frame(8'h11, 1'b1, FRAME, -1, s1);
    send_frame(8'h22, 1'b1, FRAME, LAT - 1, s2);
    chk_rise("co_11", s1);
    chk("co_rise_n2", rise_q.size(), 0);
    chk("co_data", rx_data, 8'h22);
    chk("co_valid", rx_valid, 1);
    chk("co_ovr_n", ov_q.size(), 0);
    chk_hs("co_first", 8'h11);
    rx_ready = 1'b1;
    tick(1);
    chk("co_valid_drop", rx_valid, 0);
    chk_hs("co_second", 8'h22);
    rx_ready = 1'b0;
    idle(10);

    // Reset during bit 3 of 0xF0 while an older byte is still held
    send_frame(8'h5A, 1'b1, FRAME, -1, s1);
    chk_rise("pre_5a", s1);
    send_frame(8'hF0, 1'b1, 4 * CPB + CPB / 2, -1, s2);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", rx_valid, 0);
    chk("mr_data", rx_data, 8'h00);
    chk("mr_ferr", frame_err, 0);
    chk("mr_ovr", overrun, 0);
    rx = 1'b1;
    tick(10);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    idle(20);
    chk("mr_rise_n", rise_q.size(), 0);
    chk("mr_hs_n", hs_q.size(), 0);
    send_frame(8'h0F, 1'b1, FRAME, -1, s1);
    chk_rise("0f", s1);
    chk_hs("0f", 8'h0F);
    idle(10);

    // Randomized frames, some with a bad stop bit
    fe_q.delete();
    ov_q.delete();
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(3) != 0);
      m  = decode({rs, rb, 1'b0});
      send_frame(rb, rs, FRAME, -1, s1);
      if (m[8]) begin
        chk_rise($sformatf("rnd%0d", k), s1);
        chk_hs($sformatf("rnd%0d", k), m[7:0]);
        chk($sformatf("rnd%0d_ferr_n", k), fe_q.size(), 0);
      end else begin
        chk($sformatf("rnd%0d_rise_n", k), rise_q.size(), 0);
        chk($sformatf("rnd%0d_ferr_n", k), fe_q.size(), 1);
        if (fe_q.size() > 0) chk($sformatf("rnd%0d_ferr_lat", k), fe_q.pop_front() - s1, LAT);
      end
      idle(m[8] ? $urandom_range(15) : 4 + $urandom_range(15));
    end
    chk("rnd_ovr_n", ov_q.size(), 0);
    chk("end_hs_left", hs_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
